// File: rtl/unsigned_divider_8bit.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first; 9-cycle latency for WIDTH=8, 1 cycle on divide-by-zero.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready is sampled high.
module unsigned_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_dbz;
    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == CALC)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST)
                    w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // {rem, q} shifted left by one; the remainder's top bit is always 0 between iterations
    assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_q   <= '0;
            r_div <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_div <= divisor;
            if (divisor == '0) begin
                r_q   <= '1;
                r_rem <= {1'b0, dividend};
                r_dbz <= 1'b1;
            end else begin
                r_q   <= dividend;
                r_rem <= '0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == CALC) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial;
                r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift;
                r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_unsigned_divider_8bit.sv
// Directed and randomized bench for unsigned_divider_8bit; reference results come from plain / and % arithmetic.
module tb_unsigned_divider_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    unsigned_divider_8bit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference quotient/remainder/flag from the arithmetic definition
    function automatic logic [16:0] model(input logic [7:0] dd, input logic [7:0] dv);
        if (dv == 8'd0) return {1'b1, 8'hFF, dd};
        return {1'b0, 8'(dd / dv), 8'(dd % dv)};
    endfunction

    // One transaction with out_ready held high; checks latency, ready pattern and result
    task automatic op(input logic [7:0] dd, input logic [7:0] dv);
        logic [16:0] exp;
        int lat;
        exp = model(dd, dv);
        in_valid = 1'b1; dividend = dd; divisor = dv; out_ready = 1'b1;
        check("accept_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("calc_in_ready_low", in_ready, 0);
            step();
            lat++;
        end
        check("latency", lat, (dv == 8'd0) ? 1 : 9);
        check("done_in_ready_low", in_ready, 0);
        check("quotient", quotient, exp[15:8]);
        check("remainder", remainder, exp[7:0]);
        check("div_by_zero", div_by_zero, exp[16]);
        step();
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    logic [7:0] q_dd[$];
    logic [7:0] q_dv[$];

    initial begin
        logic [16:0] e;
        logic [7:0]  hold_q, hold_r;
        logic        hold_z, stalled;
        int accepted, consumed, cyc;

        rst_n = 1'b0; in_valid = 1'b1; dividend = 8'd50; divisor = 8'd3; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
        end
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        in_valid = 1'b0; rst_n = 1'b1;
        step();
        check("after_rst_idle", in_ready, 1);

        op(8'd200, 8'd7);
        op(8'd255, 8'd1);
        op(8'd5,   8'd9);
        op(8'd255, 8'd255);
        op(8'd0,   8'd13);
        op(8'd100, 8'd0);

        // Backpressure with stray 9/3 offers while busy
        in_valid = 1'b1; dividend = 8'd200; divisor = 8'd7; out_ready = 1'b0;
        step();
        dividend = 8'd9; divisor = 8'd3;
        for (int i = 1; i <= 8; i++) begin
            check("bp_calc_out_valid", out_valid, 0);
            check("bp_calc_in_ready", in_ready, 0);
            step();
        end
        for (int i = 0; i < 7; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, 28);
            check("bp_remainder", remainder, 4);
            check("bp_dbz", div_by_zero, 0);
            if (i < 6) step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_released_idle", in_ready, 1);
        check("bp_released_ov", out_valid, 0);
        op(8'd9, 8'd3);

        // Reset in cycle 4 of a division
        in_valid = 1'b1; dividend = 8'd200; divisor = 8'd7; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        stalled = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) stalled = 1'b1;
            step();
        end
        check("midrst_no_result", stalled, 0);
        op(8'd17, 8'd5);

        // Random traffic with random backpressure; results must arrive in order
        accepted = 0; consumed = 0; cyc = 0; stalled = 1'b0;
        hold_q = '0; hold_r = '0; hold_z = 1'b0;
        while (consumed < 2000 && cyc < 60000) begin
            if (stalled) begin
                check("rnd_hold_q", quotient, hold_q);
                check("rnd_hold_r", remainder, hold_r);
                check("rnd_hold_z", div_by_zero, hold_z);
            end
            in_valid  = (accepted < 2000) && ($urandom_range(0, 3) != 0);
            dividend  = 8'($urandom);
            divisor   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                q_dd.push_back(dividend);
                q_dv.push_back(divisor);
                accepted++;
            end
            stalled = out_valid && !out_ready;
            hold_q = quotient; hold_r = remainder; hold_z = div_by_zero;
            if (out_valid && out_ready) begin
                if (q_dd.size() == 0) begin
                    check("rnd_unexpected_result", 1, 0);
                end else begin
                    logic [7:0] dd, dv;
                    dd = q_dd.pop_front();
                    dv = q_dv.pop_front();
                    e = model(dd, dv);
                    check("rnd_quotient", quotient, e[15:8]);
                    check("rnd_remainder", remainder, e[7:0]);
                    check("rnd_dbz", div_by_zero, e[16]);
                    if (dv != 8'd0) begin
                        check("rnd_identity", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
                        check("rnd_rem_lt_div", 32'(remainder < dv), 1);
                    end
                end
                consumed++;
            end
            step();
            cyc++;
        end
        check("rnd_all_consumed", consumed, 2000);
        check("rnd_queue_empty", q_dd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
